// File: rtl/rgb_to_y_pkg.sv
// Shared video constants: reference geometry, BT.601-style luma weights and
// the sequencing FSM encoding used by the luma stage and the FIR stage.
package rgb_to_y_pkg;

   localparam int unsigned VID_MAX_COLS = 1600;
   localparam int unsigned VID_MAX_ROWS = 900;

   localparam int unsigned COEF_R     = 77;
   localparam int unsigned COEF_G     = 150;
   localparam int unsigned COEF_B     = 29;
   localparam int unsigned LUMA_ROUND = 128;
   localparam int unsigned SYNC_DEPTH = 3;

   typedef enum logic {
      SYNC_WAIT = 1'b0,
      ACTIVE    = 1'b1
   } state_e;

endpackage

// File: rtl/rgb_to_y_sync_delay.sv
// Fixed-depth shift register for the {vs, hs, dv} vector so the syncs stay
// cycle-aligned with the luma pipeline.
module sync_delay #(
   parameter int unsigned DEPTH = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] sync_i,
   output logic [2:0] sync_o
);

   logic [2:0] stage_q [DEPTH];
   logic [2:0] stage_d [DEPTH];

   always_comb begin
      stage_d[0] = sync_i;
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (rst) stage_q[i] <= 3'b000;
         else     stage_q[i] <= stage_d[i];
      end
   end

   assign sync_o = stage_q[DEPTH-1];

endmodule

// File: rtl/rgb_to_y.sv
// RGB to luma conversion with a 3-stage pipeline, sync gating until the first
// vertical sync, and per-frame geometry measurement.
//
// state     | meaning
// SYNC_WAIT | after reset; syncs suppressed, counters held at 0
// ACTIVE    | locked to frame timing; syncs pass, geometry is measured
module rgb_to_y
   import rgb_to_y_pkg::*;
#(
   parameter int unsigned MAX_COLS = VID_MAX_COLS,
   parameter int unsigned MAX_ROWS = VID_MAX_ROWS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  r_i,
   input  logic [7:0]  g_i,
   input  logic [7:0]  b_i,
   input  logic        dv_i,
   input  logic        hs_i,
   input  logic        vs_i,
   output logic [7:0]  y_o,
   output logic        dv_o,
   output logic        hs_o,
   output logic        vs_o,
   output logic [10:0] frame_cols_o,
   output logic [9:0]  frame_rows_o,
   output logic        geom_err_o
);

   localparam logic [10:0] COLS_EXP = 11'(MAX_COLS);
   localparam logic [9:0]  ROWS_EXP = 10'(MAX_ROWS);

   state_e      state_q, state_d;
   logic        vs_prev_q, vs_prev_d;
   logic        dv_prev_q, dv_prev_d;
   logic [10:0] col_q, col_d;
   logic [9:0]  row_q, row_d;
   logic [10:0] frame_cols_q, frame_cols_d;
   logic [9:0]  frame_rows_q, frame_rows_d;
   logic        geom_err_q, geom_err_d;
   logic [15:0] prod_r_q, prod_r_d, prod_g_q, prod_g_d, prod_b_q, prod_b_d;
   logic [15:0] sum_q, sum_d;
   logic [7:0]  y_q, y_d;

   logic        vs_rise, dv_fall;
   logic [10:0] cols_seen;
   logic [9:0]  rows_seen;
   logic [2:0]  sync_in, sync_out;

   always_comb begin
      vs_rise  = vs_i & ~vs_prev_q;
      dv_fall  = ~dv_i & dv_prev_q;

      prod_r_d = 16'(COEF_R) * {8'd0, r_i};
      prod_g_d = 16'(COEF_G) * {8'd0, g_i};
      prod_b_d = 16'(COEF_B) * {8'd0, b_i};
      sum_d    = prod_r_q + prod_g_q + prod_b_q + 16'(LUMA_ROUND);
      y_d      = sum_q[15:8];

      state_d  = state_q;
      if (state_q == SYNC_WAIT && vs_rise) state_d = ACTIVE;

      // the vs edge that unlocks the FSM must itself reach vs_o
      sync_in  = (state_q == ACTIVE || vs_rise) ? {vs_i, hs_i, dv_i} : 3'b000;

      vs_prev_d    = vs_i;
      dv_prev_d    = (state_q == ACTIVE) & dv_i;
      col_d        = col_q;
      row_d        = row_q;
      frame_cols_d = frame_cols_q;
      frame_rows_d = frame_rows_q;
      geom_err_d   = geom_err_q;
      cols_seen    = frame_cols_q;
      rows_seen    = row_q;

      if (state_q == ACTIVE) begin
         if (dv_i && col_q != 11'h7FF) col_d = col_q + 11'd1;
         // a line ending on the vs edge is counted before the frame closes
         if (dv_fall) begin
            frame_cols_d = col_q;
            col_d        = 11'd0;
            row_d        = (row_q == 10'h3FF) ? row_q : row_q + 10'd1;
            cols_seen    = col_q;
            rows_seen    = row_d;
         end
         if (vs_rise) begin
            frame_rows_d = rows_seen;
            row_d        = 10'd0;
            geom_err_d   = (cols_seen != COLS_EXP) || (rows_seen != ROWS_EXP);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= SYNC_WAIT;
         vs_prev_q    <= 1'b0;
         dv_prev_q    <= 1'b0;
         col_q        <= '0;
         row_q        <= '0;
         frame_cols_q <= '0;
         frame_rows_q <= '0;
         geom_err_q   <= 1'b0;
         prod_r_q     <= '0;
         prod_g_q     <= '0;
         prod_b_q     <= '0;
         sum_q        <= '0;
         y_q          <= '0;
      end else begin
         state_q      <= state_d;
         vs_prev_q    <= vs_prev_d;
         dv_prev_q    <= dv_prev_d;
         col_q        <= col_d;
         row_q        <= row_d;
         frame_cols_q <= frame_cols_d;
         frame_rows_q <= frame_rows_d;
         geom_err_q   <= geom_err_d;
         prod_r_q     <= prod_r_d;
         prod_g_q     <= prod_g_d;
         prod_b_q     <= prod_b_d;
         sum_q        <= sum_d;
         y_q          <= y_d;
      end
   end

   sync_delay #(.DEPTH(SYNC_DEPTH)) u_sync_delay (
      .clk    (clk),
      .rst    (rst),
      .sync_i (sync_in),
      .sync_o (sync_out)
   );

   assign dv_o         = sync_out[0];
   assign hs_o         = sync_out[1];
   assign vs_o         = sync_out[2];
   assign y_o          = sync_out[0] ? y_q : 8'd0;
   assign frame_cols_o = frame_cols_q;
   assign frame_rows_o = frame_rows_q;
   assign geom_err_o   = geom_err_q;

endmodule

// File: tb/tb_rgb_to_y.sv
// Bench for rgb_to_y: every cycle is compared against a behavioural pipeline
// model; geometry and reset behaviour are checked with directed sequences.
module tb_rgb_to_y;

   localparam int TB_COLS = 16;
   localparam int TB_ROWS = 9;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  r_i = '0, g_i = '0, b_i = '0;
   logic        dv_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
   logic [7:0]  y_o;
   logic        dv_o, hs_o, vs_o;
   logic [10:0] frame_cols_o;
   logic [9:0]  frame_rows_o;
   logic        geom_err_o;

   rgb_to_y #(.MAX_COLS(TB_COLS), .MAX_ROWS(TB_ROWS)) dut (
      .clk          (clk),
      .rst          (rst),
      .r_i          (r_i),
      .g_i          (g_i),
      .b_i          (b_i),
      .dv_i         (dv_i),
      .hs_i         (hs_i),
      .vs_i         (vs_i),
      .y_o          (y_o),
      .dv_o         (dv_o),
      .hs_o         (hs_o),
      .vs_o         (vs_o),
      .frame_cols_o (frame_cols_o),
      .frame_rows_o (frame_rows_o),
      .geom_err_o   (geom_err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int y;
      bit dv;
      bit hs;
      bit vs;
   } exp_t;

   typedef struct {
      int r;
      int g;
      int b;
      int y;
   } vec_t;

   exp_t pipe [3];
   bit   m_active  = 1'b0;
   bit   m_vs_prev = 1'b0;
   int   checks = 0;
   int   errors = 0;

   function automatic int luma(input int r, input int g, input int b);
      return (77 * r + 150 * g + 29 * b + 128) / 256;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: model what the DUT captured at this edge, then compare the
   // outputs against what entered the pipeline two edges earlier.
   task automatic tick();
      exp_t e;
      bit   rise;
      @(posedge clk);
      if (rst) begin
         e.y = 0; e.dv = 0; e.hs = 0; e.vs = 0;
         pipe[0] = e; pipe[1] = e; pipe[2] = e;
         m_active  = 1'b0;
         m_vs_prev = 1'b0;
      end else begin
         rise = vs_i && !m_vs_prev;
         e.dv = (m_active || rise) && dv_i;
         e.hs = (m_active || rise) && hs_i;
         e.vs = (m_active || rise) && vs_i;
         e.y  = e.dv ? luma(r_i, g_i, b_i) : 0;
         if (rise) m_active = 1'b1;
         m_vs_prev = vs_i;
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = e;
      end
      #1;
      chk("pipe_y",  y_o,  pipe[2].y);
      chk("pipe_dv", dv_o, pipe[2].dv);
      chk("pipe_hs", hs_o, pipe[2].hs);
      chk("pipe_vs", vs_o, pipe[2].vs);
   endtask

   task automatic idle(input int n);
      dv_i = 0; hs_i = 0; vs_i = 0;
      repeat (n) tick();
   endtask

   task automatic vs_pulse();
      vs_i = 1; tick();
      vs_i = 0;
   endtask

   task automatic line(input int n);
      for (int c = 0; c < n; c++) begin
         r_i = 8'($urandom); g_i = 8'($urandom); b_i = 8'($urandom);
         dv_i = 1; tick();
      end
      dv_i = 0; hs_i = 1; tick();
      hs_i = 0; tick();
   endtask

   task automatic check_geom(input string name, input int cols, input int rows, input int err);
      chk({name, "_cols"}, frame_cols_o, cols);
      chk({name, "_rows"}, frame_rows_o, rows);
      chk({name, "_err"},  geom_err_o,   err);
   endtask

   task automatic check_all_zero(input string name);
      chk({name, "_y"},  y_o,  0);
      chk({name, "_dv"}, dv_o, 0);
      chk({name, "_hs"}, hs_o, 0);
      chk({name, "_vs"}, vs_o, 0);
      check_geom(name, 0, 0, 0);
   endtask

   initial begin
      vec_t vecs [8];
      int   seen;
      int   cnt;

      vecs[0] = '{255, 255, 255, 255};
      vecs[1] = '{0,   0,   0,   0};
      vecs[2] = '{100, 50,  10,  61};
      vecs[3] = '{255, 0,   0,   77};
      vecs[4] = '{0,   255, 0,   149};
      vecs[5] = '{0,   0,   255, 29};
      vecs[6] = '{1,   1,   1,   1};
      vecs[7] = '{128, 128, 128, 128};

      // reset state
      rst = 1; tick(); tick();
      check_all_zero("reset");
      rst = 0;

      // syncs toggling before any vs are suppressed
      for (int i = 0; i < 20; i++) begin
         dv_i = (i % 2) == 1; hs_i = (i % 3) == 0;
         r_i = 8'($urandom); tick();
      end
      idle(1);
      check_geom("presync", 0, 0, 0);

      // first vs: vs_o must follow it with fixed latency
      vs_i = 1; tick(); vs_i = 0;
      seen = -1;
      for (int k = 1; k <= 8 && seen < 0; k++) begin
         tick();
         if (vs_o) seen = k;
      end
      chk("vs_latency", seen, 2);
      idle(3);

      // colour table, one isolated pixel each
      for (int i = 0; i < 8; i++) begin
         r_i = 8'(vecs[i].r); g_i = 8'(vecs[i].g); b_i = 8'(vecs[i].b);
         dv_i = 1; tick();
         dv_i = 0; tick(); tick();
         chk("table_dv", dv_o, 1);
         chk("table_y",  y_o,  vecs[i].y);
         tick();
      end

      // geometry: exact frame, then a short one
      vs_pulse(); idle(2);
      for (int r = 0; r < TB_ROWS; r++) line(TB_COLS);
      vs_pulse();
      check_geom("geom_ok", TB_COLS, TB_ROWS, 0);
      for (int r = 0; r < TB_ROWS; r++) line(TB_COLS - 1);
      vs_pulse();
      check_geom("geom_short", TB_COLS - 1, TB_ROWS, 1);
      idle(5);
      chk("geom_hold", geom_err_o, 1);

      // vs rising exactly as the last line's dv falls
      vs_pulse(); idle(2);
      for (int r = 0; r < TB_ROWS - 1; r++) line(TB_COLS);
      for (int c = 0; c < TB_COLS; c++) begin
         r_i = 8'($urandom); dv_i = 1; tick();
      end
      dv_i = 0; vs_i = 1; tick(); vs_i = 0;
      check_geom("coincident", TB_COLS, TB_ROWS, 0);
      idle(2);

      // column counter saturation
      vs_pulse(); idle(1);
      line(2100);
      vs_pulse();
      check_geom("col_sat", 2047, 1, 1);

      // row counter saturation with 1-cycle dv glitches
      vs_pulse(); idle(1);
      for (int i = 0; i < 1030; i++) begin
         dv_i = 1; tick();
         dv_i = 0; tick();
      end
      vs_pulse();
      check_geom("row_sat", 1, 1023, 1);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         r_i  = 8'($urandom); g_i = 8'($urandom); b_i = 8'($urandom);
         dv_i = ($urandom % 4) != 0;
         hs_i = ($urandom % 16) == 0;
         vs_i = ($urandom % 200) == 0;
         rst  = ($urandom % 700) == 0;
         tick();
      end
      rst = 0; idle(3);

      // reset at column 800 of a line
      vs_pulse(); idle(2);
      for (int c = 0; c < 800; c++) begin
         r_i = 8'($urandom); dv_i = 1; tick();
      end
      rst = 1; tick(); rst = 0;
      check_all_zero("rst_mid");
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         dv_i = (i % 5) != 0; hs_i = (i % 7) == 0; tick();
         if (dv_o) cnt++;
      end
      chk("dv_after_rst", cnt, 0);
      idle(2);
      dv_i = 1; vs_i = 1; r_i = 8'd100; g_i = 8'd50; b_i = 8'd10; tick();
      vs_i = 0;
      seen = -1;
      for (int k = 1; k <= 8 && seen < 0; k++) begin
         tick();
         if (dv_o) seen = k;
      end
      chk("dv_resume_latency", seen, 2);
      chk("dv_resume_y", y_o, 61);
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
